ysyx_23060208_idu_sb: RTL and testbench

Scoreboarded decode/issue stage for the ysyx_23060208 NPC pipeline, sitting between IFU and EXU. It holds one instruction in a valid/allowin pipeline register and reads its source registers from an external regfile. A per-register pending-write scoreboard detects read-after-write hazards and stalls issue until the producing instruction writes back. It generalises the single-cycle IDU handshake with a parametrised register count, multiple writes in flight per register, branch-redirect flush and a stall performance counter.

---
 rtl/ysyx_23060208_idu_sb.sv | 154 +++++++++++++++
 tb/tb_ysyx_23060208_idu_sb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_idu_sb.sv
// Scoreboarded decode/issue stage between IFU and EXU.
// Optional writeback-to-issue bypass: define YSYX_23060208_WB_BYPASS_EN.
module ysyx_23060208_idu_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_to_idu_valid,
    input  logic [DATA_WIDTH-1:0] ifu_pc,
    input  logic [DATA_WIDTH-1:0] ifu_inst,
    output logic                  idu_allowin,
    output logic [REG_WIDTH-1:0]  rf_raddr1,
    output logic [REG_WIDTH-1:0]  rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_valid,
    input  logic [REG_WIDTH-1:0]  wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  flush,
    output logic                  idu_to_exu_valid,
    input  logic                  exu_allowin,
    output logic [DATA_WIDTH-1:0] idu_pc,
    output logic [DATA_WIDTH-1:0] idu_inst,
    output logic [DATA_WIDTH-1:0] idu_src1,
    output logic [DATA_WIDTH-1:0] idu_src2,
    output logic                  idu_valid_o,
    output logic [31:0]           stall_cycles
);
    localparam int NREG = 1 << REG_WIDTH;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [CNT_WIDTH-1:0]  pendCnt_q [NREG];
    logic [CNT_WIDTH-1:0]  pendCnt_d [NREG];
    logic [31:0]           stallCnt_q;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic [REG_WIDTH-1:0] rd;
    logic                 usesRs1;
    logic                 usesRs2;
    logic                 writesRd;
    logic                 bypass1;
    logic                 bypass2;
    logic                 hazard;
    logic                 readyGo;
    logic                 issue;

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];
    assign rs1    = inst_q[15 +: REG_WIDTH];
    assign rs2    = inst_q[20 +: REG_WIDTH];
    assign rd     = inst_q[7 +: REG_WIDTH];

    always_comb begin
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        writesRd = 1'b0;
        case (opcode)
            7'b0010011: begin usesRs1 = 1'b1; writesRd = 1'b1; end
            7'b0110011: begin usesRs1 = 1'b1; usesRs2 = 1'b1; writesRd = 1'b1; end
            7'b1100111: begin usesRs1 = 1'b1; writesRd = 1'b1; end
            7'b1100011: begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
            7'b0000011: begin usesRs1 = 1'b1; writesRd = 1'b1; end
            7'b0100011: begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
            7'b1110011: begin
                usesRs1  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
                writesRd = (funct3 != 3'b000);
            end
            7'b0110111, 7'b0010111, 7'b1101111: writesRd = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_23060208_WB_BYPASS_EN
    // A source whose last outstanding write retires this cycle can take wb data directly.
    assign bypass1 = wb_valid && (wb_waddr == rs1) && (rs1 != '0) && (pendCnt_q[rs1] == CNT_WIDTH'(1));
    assign bypass2 = wb_valid && (wb_waddr == rs2) && (rs2 != '0) && (pendCnt_q[rs2] == CNT_WIDTH'(1));
`else
    logic [DATA_WIDTH-1:0] unused_wbData;
    assign unused_wbData = wb_wdata;
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    assign hazard = (usesRs1 && (rs1 != '0) && (pendCnt_q[rs1] != '0) && !bypass1)
                 || (usesRs2 && (rs2 != '0) && (pendCnt_q[rs2] != '0) && !bypass2)
                 || (writesRd && (rd != '0) && (pendCnt_q[rd] == {CNT_WIDTH{1'b1}}));

    assign readyGo          = !hazard;
    assign idu_to_exu_valid = valid_q && readyGo && !flush;
    assign idu_allowin      = !flush && (!valid_q || (readyGo && exu_allowin));
    assign issue            = idu_to_exu_valid && exu_allowin;

    assign rf_raddr1    = rs1;
    assign rf_raddr2    = rs2;
    assign idu_src1     = bypass1 ? wb_wdata : rf_rdata1;
    assign idu_src2     = bypass2 ? wb_wdata : rf_rdata2;
    assign idu_pc       = pc_q;
    assign idu_inst     = inst_q;
    assign idu_valid_o  = valid_q;
    assign stall_cycles = stallCnt_q;

    // Issue and retire on the same register cancel; a stray retire never underflows.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pendCnt_d[i] = pendCnt_q[i];
            if (i != 0) begin
                if (issue && writesRd && (rd == REG_WIDTH'(i))) begin
                    if (!(wb_valid && (wb_waddr == REG_WIDTH'(i)))) begin
                        pendCnt_d[i] = pendCnt_q[i] + CNT_WIDTH'(1);
                    end
                end else if (wb_valid && (wb_waddr == REG_WIDTH'(i)) && (pendCnt_q[i] != '0)) begin
                    pendCnt_d[i] = pendCnt_q[i] - CNT_WIDTH'(1);
                end
            end else begin
                pendCnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            stallCnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                pendCnt_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (idu_allowin) begin
                valid_q <= ifu_to_idu_valid;
            end
            if (idu_allowin) begin
                pc_q   <= ifu_pc;
                inst_q <= ifu_inst;
            end
            if (valid_q && hazard && !flush) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            for (int i = 0; i < NREG; i++) begin
                pendCnt_q[i] <= pendCnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060208_idu_sb.sv
// Randomized bench for ysyx_23060208_idu_sb against a queue-based scoreboard model.
// Honours YSYX_23060208_WB_BYPASS_EN in the expected behaviour.
module tb_ysyx_23060208_idu_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_to_idu_valid;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_inst;
    logic        idu_allowin;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        idu_to_exu_valid;
    logic        exu_allowin;
    logic [31:0] idu_pc;
    logic [31:0] idu_inst;
    logic [31:0] idu_src1;
    logic [31:0] idu_src2;
    logic        idu_valid_o;
    logic [31:0] stall_cycles;

`ifdef YSYX_23060208_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ysyx_23060208_idu_sb dut (
        .clk(clk), .rst(rst),
        .ifu_to_idu_valid(ifu_to_idu_valid), .ifu_pc(ifu_pc), .ifu_inst(ifu_inst),
        .idu_allowin(idu_allowin),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush),
        .idu_to_exu_valid(idu_to_exu_valid), .exu_allowin(exu_allowin),
        .idu_pc(idu_pc), .idu_inst(idu_inst), .idu_src1(idu_src1), .idu_src2(idu_src2),
        .idu_valid_o(idu_valid_o), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    logic [31:0] rfModel [32];
    assign rf_rdata1 = rfModel[rf_raddr1];
    assign rf_rdata2 = rfModel[rf_raddr2];

    int          mPend [32];
    bit          mValid;
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mStall;
    int          outQ [$];
    int          nChecks;
    int          nErrors;

    function automatic bit usesRs1(logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        return (op inside {7'b0010011, 7'b0110011, 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011})
            || (op == 7'b1110011 && f3 inside {3'b001, 3'b010, 3'b011});
    endfunction

    function automatic bit usesRs2(logic [31:0] ins);
        return ins[6:0] inside {7'b0110011, 7'b1100011, 7'b0100011};
    endfunction

    function automatic bit writesRd(logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        return (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b0000011, 7'b0010011, 7'b0110011})
            || (op == 7'b1110011 && ins[14:12] != 3'b000);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare combinational outputs, then advance the model across the edge.
    task automatic applyStimulus(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                                 input bit ea, input bit fl, input bit rs,
                                 input bit wv, input logic [4:0] wa, input logic [31:0] wd);
        int          rs1, rs2, rd;
        bit          byp1, byp2, hz, toExu, allow, issue;
        int          newPend [32];
        int          idx [$];
        logic [31:0] e1, e2;

        ifu_to_idu_valid = iv; ifu_inst = ins; ifu_pc = pc;
        exu_allowin = ea; flush = fl; rst = rs;
        wb_valid = wv; wb_waddr = wa; wb_wdata = wd;
        #1;

        rs1 = int'(mInst[19:15]);
        rs2 = int'(mInst[24:20]);
        rd  = int'(mInst[11:7]);
        byp1 = BYP && wv && int'(wa) == rs1 && rs1 != 0 && mPend[rs1] == 1;
        byp2 = BYP && wv && int'(wa) == rs2 && rs2 != 0 && mPend[rs2] == 1;
        hz = (usesRs1(mInst) && rs1 != 0 && mPend[rs1] > 0 && !byp1)
          || (usesRs2(mInst) && rs2 != 0 && mPend[rs2] > 0 && !byp2)
          || (writesRd(mInst) && rd != 0 && mPend[rd] >= 3);
        toExu = mValid && !hz && !fl;
        allow = !fl && (!mValid || (!hz && ea));
        e1 = byp1 ? wd : rfModel[rs1];
        e2 = byp2 ? wd : rfModel[rs2];

        checkOutput("raddr1", 64'(rf_raddr1), 64'(rs1));
        checkOutput("raddr2", 64'(rf_raddr2), 64'(rs2));
        checkOutput("valid_o", 64'(idu_valid_o), 64'(mValid));
        checkOutput("to_exu_valid", 64'(idu_to_exu_valid), 64'(toExu));
        checkOutput("allowin", 64'(idu_allowin), 64'(allow));
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(mStall));
        if (toExu) begin
            checkOutput("pc", 64'(idu_pc), 64'(mPc));
            checkOutput("inst", 64'(idu_inst), 64'(mInst));
            checkOutput("src1", 64'(idu_src1), 64'(e1));
            checkOutput("src2", 64'(idu_src2), 64'(e2));
        end

        issue = toExu && ea;
        newPend = mPend;
        if (issue && writesRd(mInst) && rd != 0) begin
            newPend[rd]++;
            outQ.push_back(rd);
        end
        if (wv && wa != 0) begin
            if (issue && writesRd(mInst) && rd == int'(wa)) newPend[wa]--;
            else if (mPend[wa] > 0) newPend[wa]--;
            idx = outQ.find_first_index(x) with (x == int'(wa));
            if (idx.size() > 0) outQ.delete(idx[0]);
        end

        @(posedge clk);
        #1;
        if (rs) begin
            mValid = 1'b0; mPc = '0; mInst = '0; mStall = '0;
            foreach (mPend[i]) mPend[i] = 0;
            outQ.delete();
        end else begin
            if (mValid && hz && !fl) mStall = mStall + 32'd1;
            if (fl) mValid = 1'b0;
            else if (allow) mValid = iv;
            if (allow) begin mPc = pc; mInst = ins; end
            mPend = newPend;
        end
        if (wv && wa != 0) rfModel[wa] = wd;
    endtask

    function automatic logic [31:0] genInst();
        logic [6:0] ops [11] = '{7'b0010011, 7'b0110011, 7'b1100111, 7'b1100011, 7'b0000011,
                                 7'b0100011, 7'b1110011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b0001111};
        logic [4:0] r [3];
        foreach (r[i]) r[i] = ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'($urandom % 4);
        return {7'($urandom), r[2], r[1], 3'($urandom), r[0], ops[$urandom % 11]};
    endfunction

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADD_X2  = 32'h00108133;
    localparam logic [31:0] ADDI_X3 = 32'h00300193;
    localparam logic [31:0] ADDI_X5 = 32'h00100293;

    initial begin
        nChecks = 0; nErrors = 0;
        foreach (rfModel[i]) rfModel[i] = '0;
        mValid = 1'b0; mPc = '0; mInst = '0; mStall = '0;
        foreach (mPend[i]) mPend[i] = 0;
        rst = 1'b1; ifu_to_idu_valid = 1'b0; ifu_pc = '0; ifu_inst = '0;
        exu_allowin = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_waddr = '0; wb_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset and producer/consumer stall");
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 0);
        applyStimulus(1, ADDI_X1, 32'h80000000, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, ADD_X2, 32'h80000004, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h80000008, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h80000008, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h80000008, 1, 0, 0, 1, 5'd1, 32'd5);
        applyStimulus(0, 0, 32'h80000008, 1, 0, 0, 0, 0, 0);
        checkOutput("plan_stall_count", 64'(stall_cycles), BYP ? 64'd2 : 64'd3);

        $display("[TB] flush of a stalled consumer");
        applyStimulus(1, ADDI_X1, 32'h80000010, 1, 0, 0, 1, 5'd2, 32'd9);
        applyStimulus(1, ADD_X2, 32'h80000014, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("flush_valid", 64'(idu_valid_o), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 5'd1, 32'd7);

        $display("[TB] scoreboard saturation");
        for (int k = 0; k < 4; k++) applyStimulus(1, ADDI_X3, 32'h100 + 32'(4 * k), 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 5'd3, 32'd3);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);

        $display("[TB] EXU backpressure");
        applyStimulus(1, ADDI_X5, 32'h200, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, genInst(), 32'(k), 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 4000; n++) begin
            bit          wv;
            logic [4:0]  wa;
            if (outQ.size() > 0 && $urandom % 3 == 0) begin
                wv = 1'b1;
                wa = 5'(outQ[$urandom_range(0, outQ.size() - 1)]);
            end else if ($urandom % 20 == 0) begin
                wv = 1'b1; wa = 5'd0;
            end else begin
                wv = 1'b0; wa = 5'($urandom);
            end
            applyStimulus($urandom % 4 != 0, genInst(), $urandom, $urandom % 5 != 0,
                          $urandom % 25 == 0, $urandom % 400 == 0, wv, wa, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
